inst_mem_loader: RTL and testbench
==================================

# inst_mem_loader

Debug-side writer for the instruction memory. Accepts a byte stream over a valid/ready handshake and packs it little-endian into 32-bit words. Writes each word through the instruction memory's debug write port at consecutive word addresses. Holds the IF/ID stage (bubble/flush) while a load session runs, so the core never fetches a half-loaded image.

## Interface
Parameters:
- `CNT_W`, default 14: width of the word counter; holds up to 8192 words, the full 13-bit instruction memory index.

Ports:
- `clk`  in  1  core clock
- `rst_n`  in  1  synchronous, active-low reset
- `start`  in  1  one-cycle request to begin a session; sampled only in IDLE
- `base_addr`  in  30  first word address [31:2]; latched on accepted `start`
- `word_count`  in  CNT_W  number of words to load; latched on accepted `start`
- `byte_valid`  in  1  `byte_data` is valid
- `byte_data`  in  8  next image byte
- `byte_ready`  out  1  loader accepts a byte this cycle
- `mem_we`  out  1  instruction memory write enable
- `mem_addr`  out  30  word address [31:2] to the memory debug port
- `mem_wdata`  out  32  write data
- `mem_rdata`  in  32  combinational read-back of `mem_addr`; used only with the read-back check
- `cpu_hold`  out  1  drive into IF/ID bubble and flush while loading
- `busy`  out  1  session in progress
- `done`  out  1  one-cycle pulse at session end
- `error`  out  1  sticky read-back mismatch flag; cleared by the next accepted `start`
- `words_written`  out  CNT_W  words written in the current or last session

## Operation
- States: IDLE, COLLECT, WRITE, CHECK (compiled in only with the read-back check), DONE.
- IDLE:
  - `start`=1 with `word_count`≠0: latch address and count, clear byte index, `words_written` and `error`, then go to COLLECT.
  - `start`=1 with `word_count`=0: go to DONE. No write occurs.
- COLLECT:
  - `byte_ready`=1.
  - Each handshake (`byte_valid`&&`byte_ready`) stores the byte in lane index*8. The first byte goes to [7:0].
  - The 4th accepted byte moves the FSM to WRITE.
- WRITE:
  - `mem_we`=1 for exactly one cycle with the latched address and assembled word.
  - `words_written`+1, remaining count −1.
  - Next state is CHECK if compiled in. Otherwise DONE if remaining reaches 0, else COLLECT with address+1.
- CHECK: compare `mem_rdata` against `mem_wdata` at the unchanged `mem_addr`. A mismatch sets `error`, and the session continues. Exits to DONE or COLLECT with address+1.
- DONE: `done`=1 for one cycle, then IDLE.
- Address increments modulo 2^30. The memory uses only bits [14:2], so an image crossing 8192 words wraps onto word 0. This is intended.
- `start` outside IDLE is ignored.
- Bytes presented outside COLLECT are not consumed (`byte_ready`=0).

## Timing
- All outputs are registered. `cpu_hold` = `busy`.
- Reset values: state IDLE; `byte_ready`, `mem_we`, `busy`, `cpu_hold`, `done`, `error` = 0; `mem_addr`, `mem_wdata`, `words_written` = 0.
- `start` accepted at edge N: `busy`/`byte_ready` high from cycle N+1.
- With `byte_valid` held high: 5 cycles per word (6 with CHECK).
- `done` rises the cycle after the final WRITE (or CHECK), and `busy` falls in the same cycle.
- `word_count`=0: `done` at N+1, `busy` never rises.
- Reset mid-session: on the next edge return to IDLE with all outputs at reset values. Partially collected bytes are discarded, and no write is issued.

## Configuration
- `INST_LOADER_READBACK_EN` defined: CHECK state present and `error` live. Throughput is 6 cycles per word.
- Undefined: no CHECK state, `error` tied 0, `mem_rdata` ignored. Throughput is 5 cycles per word.

## Structure
- Package `inst_loader_pkg`: state enum, `WORD_BYTES`=4, default `CNT_W`=14.
- Sub-module `byte_packer`: handles the 2-bit lane index, the 32-bit shift/insert register and the word-complete flag. Cleared on `start` and on reset.
- The top level holds the FSM, address register and counters.

## Test plan
- Reset with `rst_n`=0 for 2 cycles → all outputs 0, `byte_ready`=0.
- `start`, base 0x0, count 2, bytes 13 00 00 00 93 00 10 00 → writes 0x00000013 at word 0 and 0x00100093 at word 1. One `mem_we` pulse each, `done` one pulse, `words_written`=2, `cpu_hold` high throughout.
- Same image with `byte_valid` toggling every other cycle → identical writes. No byte is dropped or duplicated.
- `start` with count 0 → `done` the next cycle, no `mem_we`, `busy` stays 0.
- Reset after 2 bytes of the first word → IDLE, no write. A fresh session at base 0x10 writes its first word to 0x10 with the correct byte order.
- With `INST_LOADER_READBACK_EN`, force `mem_rdata`=0xDEADBEEF during CHECK → `error`=1, session completes, `done` pulses. The next `start` clears `error`.

Source files
------------

// File: rtl/inst_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// The CHECK state exists only when INST_LOADER_READBACK_EN is defined.
package inst_loader_pkg;

  localparam int WORD_BYTES    = 4;
  localparam int LANE_W        = $clog2(WORD_BYTES);
  localparam int WORD_W        = WORD_BYTES * 8;
  localparam int DEFAULT_CNT_W = 14;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_WRITE   = 3'd2,
`ifdef INST_LOADER_READBACK_EN
    S_CHECK   = 3'd3,
`endif
    S_DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/byte_packer.sv
// Little-endian byte-to-word packer: byte lane 0 lands in [7:0].
// Flags the accept that completes a word and presents the full word alongside it.
module byte_packer
  import inst_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              accept,
  input  logic [7:0]        byte_in,
  output logic [WORD_W-1:0] word,
  output logic              word_done
);

  logic [LANE_W-1:0] lane_idx;
  logic [WORD_W-1:0] shift_reg;

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    word = shift_reg;
    word[{lane_idx, 3'b000} +: 8] = byte_in;
  end

  assign word_done = accept && (lane_idx == LANE_W'(WORD_BYTES - 1));

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      lane_idx  <= '0;
      shift_reg <= '0;
    end else if (accept) begin
      lane_idx  <= lane_idx + LANE_W'(1);
      shift_reg <= word_done ? '0 : word;
    end
  end

endmodule

// File: rtl/inst_mem_loader.sv
// Debug-side loader: packs a byte stream into words and writes them to instruction memory.
// Optional read-back check of each written word: define INST_LOADER_READBACK_EN.
module inst_mem_loader
  import inst_loader_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [29:0]       base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [29:0]       mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  words_written
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   remain_q;
  logic               accept_start;
  logic               byte_accept;
  logic               advance_addr;
  logic [WORD_W-1:0]  packed_word;
  logic               word_done;

  assign accept_start = (state_q == S_IDLE) && start;
  assign byte_accept  = byte_valid && byte_ready;

  byte_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (accept_start),
    .accept    (byte_accept),
    .byte_in   (byte_data),
    .word      (packed_word),
    .word_done (word_done)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = (word_count != '0) ? S_COLLECT : S_DONE;
      S_COLLECT: if (word_done) state_d = S_WRITE;
`ifdef INST_LOADER_READBACK_EN
      S_WRITE:   state_d = S_CHECK;
      // remain_q was already decremented on leaving WRITE
      S_CHECK:   state_d = (remain_q == '0) ? S_DONE : S_COLLECT;
`else
      S_WRITE:   state_d = (remain_q == CNT_W'(1)) ? S_DONE : S_COLLECT;
`endif
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

`ifdef INST_LOADER_READBACK_EN
  assign advance_addr = (state_q == S_CHECK) && (state_d == S_COLLECT);
`else
  assign advance_addr = (state_q == S_WRITE) && (state_d == S_COLLECT);
`endif

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      remain_q      <= '0;
      busy          <= 1'b0;
      byte_ready    <= 1'b0;
      mem_we        <= 1'b0;
      done          <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      words_written <= '0;
    end else begin
      state_q    <= state_d;
      busy       <= (state_d != S_IDLE) && (state_d != S_DONE);
      byte_ready <= (state_d == S_COLLECT);
      mem_we     <= (state_d == S_WRITE);
      done       <= (state_d == S_DONE);

      if (accept_start && (word_count != '0)) begin
        mem_addr      <= base_addr;
        remain_q      <= word_count;
        words_written <= '0;
      end
      if (word_done) mem_wdata <= packed_word;
      if (state_q == S_WRITE) begin
        words_written <= words_written + CNT_W'(1);
        remain_q      <= remain_q - CNT_W'(1);
      end
      if (advance_addr) mem_addr <= mem_addr + 30'd1;
    end
  end

  assign cpu_hold = busy;

`ifdef INST_LOADER_READBACK_EN
  logic error_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      error_q <= 1'b0;
    end else if (accept_start) begin
      error_q <= 1'b0;
    end else if ((state_q == S_CHECK) && (mem_rdata != mem_wdata)) begin
      error_q <= 1'b1;
    end
  end

  assign error = error_q;
`else
  logic unused_rdata;
  assign unused_rdata = ^mem_rdata;
  assign error        = 1'b0;
`endif

endmodule

// File: tb/tb_inst_mem_loader.sv
// Self-checking bench for inst_mem_loader: session table plus reset and read-back corner cases.
// Build with INST_LOADER_READBACK_EN defined to exercise the CHECK path.
module tb_inst_mem_loader;

  localparam int CNT_W = 14;
`ifdef INST_LOADER_READBACK_EN
  localparam int PER_WORD = 6;
`else
  localparam int PER_WORD = 5;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [29:0]       base_addr;
  logic [CNT_W-1:0]  word_count;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              mem_we;
  logic [29:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              error;
  logic [CNT_W-1:0]  words_written;

  inst_mem_loader #(.CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .base_addr     (base_addr),
    .word_count    (word_count),
    .byte_valid    (byte_valid),
    .byte_data     (byte_data),
    .byte_ready    (byte_ready),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .cpu_hold      (cpu_hold),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .words_written (words_written)
  );

  always #5 clk = ~clk;

  typedef struct {
    string            name;
    logic [29:0]      base;
    logic [CNT_W-1:0] count;
    logic [63:0]      bytes;   // byte i of the stream is bytes[i*8 +: 8]
    bit               toggle;  // byte_valid only every other cycle
    logic [29:0]      a0, a1;
    logic [31:0]      w0, w1;
  } vec_t;

  typedef struct {
    logic [29:0] a;
    logic [31:0] d;
  } wr_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   we_cnt = 0;
  bit   force_bad = 1'b0;
  wr_t  exp_q[$];
  logic [31:0] mem [0:8191];
  vec_t tbl [5];

  assign mem_rdata = force_bad ? 32'hDEAD_BEEF : mem[mem_addr[12:0]];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) if (mem_we) mem[mem_addr[12:0]] <= mem_wdata;

  // Write scoreboard: sampled mid-cycle, away from the active edge
  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      wr_t e;
      we_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_write_addr", {34'h0, mem_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", {34'h0, mem_addr}, {34'h0, e.a});
        check("wr_data", {32'h0, mem_wdata}, {32'h0, e.d});
      end
    end
  end

  task automatic run_session(input vec_t v);
    int cycles, bi, we0;
    bit hold_ok, seen_done;
    if (v.count >= 1) exp_q.push_back('{a: v.a0, d: v.w0});
    if (v.count >= 2) exp_q.push_back('{a: v.a1, d: v.w1});
    we0        = we_cnt;
    base_addr  = v.base;
    word_count = v.count;
    start      = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    cycles    = 1;
    bi        = 0;
    hold_ok   = 1'b1;
    seen_done = 1'b0;
    while (!seen_done && cycles < 200) begin
      if (done) begin
        seen_done = 1'b1;
      end else begin
        if (v.count != 0 && !(busy && cpu_hold)) hold_ok = 1'b0;
        byte_valid = (bi < 4 * int'(v.count)) && (!v.toggle || cycles[0]);
        byte_data  = (bi < 8) ? v.bytes[bi*8 +: 8] : 8'h00;
        if (byte_valid && byte_ready) bi++;
        @(posedge clk); #1;
        cycles++;
      end
    end
    byte_valid = 1'b0;
    check({v.name, "/done_seen"}, seen_done, 1);
    if (!v.toggle) check({v.name, "/latency"}, cycles, PER_WORD * int'(v.count) + 1);
    check({v.name, "/busy_at_done"}, busy, 0);
    check({v.name, "/hold_throughout"}, hold_ok, 1);
    if (v.count != 0) check({v.name, "/words_written"}, words_written, v.count);
    check({v.name, "/we_pulses"}, we_cnt - we0, v.count);
    check({v.name, "/sb_empty"}, exp_q.size(), 0);
    @(posedge clk); #1;
    check({v.name, "/done_one_cycle"}, {done, busy}, 2'b00);
`ifndef INST_LOADER_READBACK_EN
    check({v.name, "/error_tied"}, error, 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int we0;
    vec_t v;
    for (int i = 0; i < 8192; i++) mem[i] = 32'h0;

    tbl[0] = '{"basic",  30'h0,        14'd2, 64'h0010_0093_0000_0013, 1'b0,
               30'h0, 30'h1, 32'h0000_0013, 32'h0010_0093};
    tbl[1] = '{"toggle", 30'h0,        14'd2, 64'h0010_0093_0000_0013, 1'b1,
               30'h0, 30'h1, 32'h0000_0013, 32'h0010_0093};
    tbl[2] = '{"wrap",   30'h3FFF_FFFF, 14'd2, 64'h0807_0605_0403_0201, 1'b0,
               30'h3FFF_FFFF, 30'h0, 32'h0403_0201, 32'h0807_0605};
    tbl[3] = '{"top",    30'h1FFF,     14'd1, 64'h0000_0000_DEAD_BEEF, 1'b0,
               30'h1FFF, 30'h0, 32'hDEAD_BEEF, 32'h0};
    tbl[4] = '{"zero",   30'h55,       14'd0, 64'h0, 1'b0,
               30'h0, 30'h0, 32'h0, 32'h0};

    rst_n      = 1'b0;
    start      = 1'b0;
    base_addr  = '0;
    word_count = '0;
    byte_valid = 1'b0;
    byte_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ctrl", {byte_ready, mem_we, busy, cpu_hold, done, error}, 6'b0);
    check("reset_addr", {34'h0, mem_addr}, 64'h0);
    check("reset_wdata", {32'h0, mem_wdata}, 64'h0);
    check("reset_words", words_written, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) run_session(tbl[i]);

    // Reset after two bytes of the first word: nothing may be written
    we0        = we_cnt;
    base_addr  = 30'h0;
    word_count = 14'd1;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("mid_rst/ready", byte_ready, 1);
    byte_valid = 1'b1; byte_data = 8'hAA;
    @(posedge clk); #1;
    byte_data = 8'hBB;
    @(posedge clk); #1;
    byte_valid = 1'b0;
    rst_n      = 1'b0;
    @(posedge clk); #1;
    check("mid_rst/ctrl", {byte_ready, mem_we, busy, cpu_hold, done, error}, 6'b0);
    check("mid_rst/addr_data", {mem_addr, mem_wdata}, 64'h0);
    check("mid_rst/words", words_written, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("mid_rst/no_write", we_cnt - we0, 0);
    v = '{"fresh", 30'h10, 14'd1, 64'h0000_0000_0000_0537, 1'b0,
          30'h10, 30'h0, 32'h0000_0537, 32'h0};
    run_session(v);

`ifdef INST_LOADER_READBACK_EN
    force_bad = 1'b1;
    v = '{"rb_bad", 30'h20, 14'd1, 64'h0000_0000_0000_0001, 1'b0,
          30'h20, 30'h0, 32'h0000_0001, 32'h0};
    run_session(v);
    force_bad = 1'b0;
    check("rb_bad/error_set", error, 1);
    v = '{"rb_ok", 30'h21, 14'd1, 64'h0000_0000_1234_5678, 1'b0,
          30'h21, 30'h0, 32'h1234_5678, 32'h0};
    run_session(v);
    check("rb_ok/error_cleared", error, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
